csa_stream_accumulator: RTL and testbench

//  Sequential multi-operand adder. Accepts a batch of up to M N-bit operands, one per cycle, over a

---
 rtl/csa_stream_accumulator_if.sv | 27 ++
 rtl/csa_stream_accumulator.sv | 118 +++++++++++
 tb/tb_csa_stream_accumulator.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_accumulator_if.sv
// Operand and result streams of the carry-save stream accumulator.
interface csa_stream_accumulator_if #(
  parameter int N = 4,
  parameter int M = 8
);
  localparam int W  = N + $clog2(M);
  localparam int CW = $clog2(M + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Sequential multi-operand adder: operands are folded into a carry-save pair
// one per cycle, then the pair is resolved by iterative carry propagation.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ACCUM   | accepting operands, 3:2 compression into (s, c)
//   RESOLVE | folding c into s one carry step per cycle until c == 0
//   DONE    | result held in s until the downstream takes it
module csa_stream_accumulator #(
  parameter int N      = 4,
  parameter int M      = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  csa_stream_accumulator_if.slave  bus
);
  localparam int W  = N + $clog2(M);
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  s;
  logic [W-1:0]  c;
  logic [W-1:0]  x;
  logic [CW-1:0] cnt;
  logic          out_valid_q;
  logic          accept;
  logic          batch_end;
  logic          take;

  assign accept    = (state == ACCUM) && bus.in_valid;
  assign batch_end = bus.in_last || (cnt == CW'(M - 1));
  // The result is only handed over once out_valid is visible, so the handshake
  // is qualified by the registered valid rather than the state alone.
  assign take      = (state == DONE) && out_valid_q && bus.out_ready;

  // Operand extension to the result width.
  always_comb begin
    x = '0;
    if (SIGNED)
      x = {{(W-N){bus.in_data[N-1]}}, bus.in_data};
    else
      x = {{(W-N){1'b0}}, bus.in_data};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ACCUM;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && batch_end) state_next = RESOLVE;
      RESOLVE: if (c == '0)             state_next = DONE;
      DONE:    if (take)                state_next = ACCUM;
      default:                          state_next = ACCUM;
    endcase
  end

  // Output decode; result fields read as zero while no result is offered.
  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.out_valid = out_valid_q;
    bus.out_data  = out_valid_q ? s   : '0;
    bus.out_count = out_valid_q ? cnt : '0;
  end

  // Carry-save datapath, operand count and the registered result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s           <= '0;
      c           <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state == DONE) && !take;
      case (state)
        ACCUM: begin
          if (accept) begin
            s   <= s ^ c ^ x;
            c   <= ((s & c) | (s & x) | (c & x)) << 1;
            cnt <= cnt + CW'(1);
          end
        end
        RESOLVE: begin
          if (c != '0) begin
            s <= s ^ c;
            c <= (s & c) << 1;
          end
        end
        DONE: begin
          if (take) begin
            s   <= '0;
            c   <= '0;
            cnt <= '0;
          end
        end
        default: begin
          s   <= '0;
          c   <= '0;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: one unsigned and one signed
// instance share clock and reset; sel picks which one the stimulus drives.
module tb_csa_stream_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       sel = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_stream_accumulator_if #(.N(4), .M(8)) ifu ();
  csa_stream_accumulator_if #(.N(4), .M(8)) ifs ();

  assign ifu.in_valid  = in_valid & ~sel;
  assign ifu.in_data   = in_data;
  assign ifu.in_last   = in_last;
  assign ifu.out_ready = out_ready & ~sel;
  assign ifs.in_valid  = in_valid & sel;
  assign ifs.in_data   = in_data;
  assign ifs.in_last   = in_last;
  assign ifs.out_ready = out_ready & sel;

  csa_stream_accumulator #(.N(4), .M(8), .SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifu.slave)
  );

  csa_stream_accumulator #(.N(4), .M(8), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs.slave)
  );

  wire       o_valid = sel ? ifs.out_valid : ifu.out_valid;
  wire       o_ready = sel ? ifs.in_ready  : ifu.in_ready;
  wire [6:0] o_data  = sel ? ifs.out_data  : ifu.out_data;
  wire [3:0] o_count = sel ? ifs.out_count : ifu.out_count;

  // Called at a negedge; leaves at the negedge after the accepting edge.
  task automatic send(input logic [3:0] d, input logic last, output int t);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    t        = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Latency in edges from the last accept to out_valid, -1 on timeout.
  task automatic wait_valid(input int t, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) begin
        lat = cyc - t;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifu.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", ifu.in_ready); end
    n_cmp++; if (ifu.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", ifu.out_valid); end
    n_cmp++; if (ifu.out_data !== 7'd0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", ifu.out_data); end
    n_cmp++; if (ifu.out_count !== 4'd0) begin n_bad++; $display("FAIL reset_out_count got %0d want 0", ifu.out_count); end
    n_cmp++; if (ifs.in_ready !== 1'b1 || ifs.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_signed got rdy=%b vld=%b want 1 0", ifs.in_ready, ifs.out_valid); end
  endtask

  task automatic test_back_to_back;
    int t, lat;
    sel = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'hF, 1'b0, t);
    wait_valid(t, lat);
    n_cmp++; if (lat < 2 || lat > 9) begin n_bad++; $display("FAIL b2b_latency got %0d want 2..9", lat); end
    n_cmp++; if (o_data !== 7'd120) begin n_bad++; $display("FAIL b2b_data got %0d want 120", o_data); end
    n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL b2b_count got %0d want 8", o_count); end
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_one_cycle got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got %b want 1", o_ready); end
  endtask

  task automatic test_early_last;
    int t, lat;
    logic blocked;
    sel = 1'b0;
    out_ready = 1'b0;
    send(4'd5, 1'b0, t);
    send(4'd6, 1'b0, t);
    send(4'd7, 1'b1, t);
    in_valid = 1'b1;
    in_data  = 4'd9;
    blocked  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (o_ready !== 1'b0) blocked = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (blocked !== 1'b1) begin n_bad++; $display("FAIL early_ready_blocked got %b want 1", blocked); end
    in_valid = 1'b0;
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'd18) begin n_bad++; $display("FAIL early_data got %0d want 18", o_data); end
    n_cmp++; if (o_count !== 4'd3) begin n_bad++; $display("FAIL early_count got %0d want 3", o_count); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL early_handoff got vld=%b rdy=%b want 0 1", o_valid, o_ready); end
  endtask

  task automatic test_latency;
    int t, lat;
    sel = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'd0, 1'b0, t);
    wait_valid(t, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zero_latency got %0d want 2", lat); end
    n_cmp++; if (o_data !== 7'd0 || o_count !== 4'd8) begin n_bad++; $display("FAIL zero_result got %0d/%0d want 0/8", o_data, o_count); end
    @(negedge clk);
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, t);
    wait_valid(t, lat);
    n_cmp++; if (lat < 2 || lat > 9) begin n_bad++; $display("FAIL ramp_latency got %0d want 2..9", lat); end
    n_cmp++; if (o_data !== 7'd36) begin n_bad++; $display("FAIL ramp_data got %0d want 36", o_data); end
    n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL ramp_count got %0d want 8", o_count); end
    @(negedge clk);
  endtask

  task automatic test_hold;
    int t, lat;
    sel = 1'b0;
    out_ready = 1'b0;
    send(4'd3, 1'b0, t);
    send(4'd4, 1'b1, t);
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'd7 || o_count !== 4'd2) begin n_bad++; $display("FAIL hold_result got %0d/%0d want 7/2", o_data, o_count); end
    in_valid = 1'b1;
    in_data  = 4'hF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== 7'd7 || o_count !== 4'd2 || o_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable cycle %0d got vld=%b data=%0d cnt=%0d rdy=%b want 1 7 2 0", i, o_valid, o_data, o_count, o_ready);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release got vld=%b rdy=%b want 0 1", o_valid, o_ready); end
    send(4'd2, 1'b1, t);
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'd2 || o_count !== 4'd1) begin n_bad++; $display("FAIL hold_next_batch got %0d/%0d want 2/1", o_data, o_count); end
    @(negedge clk);
  endtask

  task automatic test_signed;
    int t, lat;
    sel = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'h8, 1'b0, t);
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'h40 || o_count !== 4'd8) begin n_bad++; $display("FAIL signed_min got %h/%0d want 40/8", o_data, o_count); end
    @(negedge clk);
    send(4'hF, 1'b0, t);
    send(4'h2, 1'b1, t);
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'h01 || o_count !== 4'd2) begin n_bad++; $display("FAIL signed_mixed got %h/%0d want 01/2", o_data, o_count); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(4'h8, 1'b0, t);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL signed_abort got vld=%b rdy=%b want 0 1", o_valid, o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'h1, 1'b1, t);
    wait_valid(t, lat);
    n_cmp++; if (o_data !== 7'h01 || o_count !== 4'd1) begin n_bad++; $display("FAIL signed_after_abort got %h/%0d want 01/1", o_data, o_count); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_early_last();
    test_latency();
    test_hold();
    test_signed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
